// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle main controller.
// Contents:
//   INST_WIDTH        instruction word width
//   OPC_*             supported major opcodes (LOAD, STORE, ARITH, BRANCH)
//   FUNCT3_*/FUNCT7_* funct fields accepted by the ALU control decoder
//   ctrl_state_t      controller state encoding (3 bits, exported on state_o)
//   alu_ctrl_t        ALU operation encoding driven on alu_ctrl_o
//   op_class_t        instruction class latched at fetch time
package multicycle_ctrl_fsm_pkg;

   localparam int unsigned INST_WIDTH = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ARITH  = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
   localparam logic [2:0] FUNCT3_AND    = 3'b111;
   localparam logic [2:0] FUNCT3_OR     = 3'b110;
   localparam logic [2:0] FUNCT3_BEQ    = 3'b000;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      StFetch     = 3'd0,
      StDecode    = 3'd1,
      StExecute   = 3'd2,
      StMem       = 3'd3,
      StWriteback = 3'd4,
      StHalt      = 3'd5
   } ctrl_state_t;

   typedef enum logic [2:0] {
      AluAnd = 3'b000,
      AluOr  = 3'b001,
      AluAdd = 3'b010,
      AluSub = 3'b110
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      OpArith,
      OpLoad,
      OpStore,
      OpBranch
   } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_ctrl_decoder.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports:
//   opcode_i    instruction bits [6:0]
//   funct3_i    instruction bits [14:12]
//   funct7_i    instruction bits [31:25]
//   alu_ctrl_o  ALU operation for this instruction (ADD when not meaningful)
//   op_class_o  instruction class (ARITH/LOAD/STORE/BRANCH)
//   illegal_o   opcode or funct combination not supported
module multicycle_ctrl_fsm_alu_ctrl_decoder
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output alu_ctrl_t  alu_ctrl_o,
   output op_class_t  op_class_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctrl_o = AluAdd;
      op_class_o = OpArith;
      illegal_o  = 1'b0;
      case (opcode_i)
         OPC_ARITH: begin
            op_class_o = OpArith;
            if (funct3_i == FUNCT3_ADDSUB && funct7_i == FUNCT7_BASE) begin
               alu_ctrl_o = AluAdd;
            end else if (funct3_i == FUNCT3_ADDSUB && funct7_i == FUNCT7_ALT) begin
               alu_ctrl_o = AluSub;
            end else if (funct3_i == FUNCT3_AND && funct7_i == FUNCT7_BASE) begin
               alu_ctrl_o = AluAnd;
            end else if (funct3_i == FUNCT3_OR && funct7_i == FUNCT7_BASE) begin
               alu_ctrl_o = AluOr;
            end else begin
               illegal_o = 1'b1;
            end
         end
         // Address generation: base + immediate, any access width accepted.
         OPC_LOAD:  op_class_o = OpLoad;
         OPC_STORE: op_class_o = OpStore;
         OPC_BRANCH: begin
            op_class_o = OpBranch;
            alu_ctrl_o = AluSub;
            illegal_o  = (funct3_i != FUNCT3_BEQ);
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main controller for the RV64 subset datapath (LOAD/STORE/ARITH/BEQ).
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, handshakes with instruction and data
// memory and drives the PC, IR, register file, ALU and memory strobes.
// Optional feature macro: CTRL_PERF_CNT_EN enables the cycle/retired performance counters;
// when undefined both counter outputs are tied to zero.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   en_i                  allow a new fetch (only looked at in FETCH)
//   instr_i, imem_ready_i instruction word and its valid/ready
//   dmem_ready_i          data access complete
//   alu_zero_i            ALU zero flag for BEQ
//   imem_req_o, ir_load_o fetch request and IR latch strobe
//   pc_write_o, pc_src_o  PC update pulse and source select (1: branch target)
//   alu_src_b_o, alu_ctrl_o  ALU operand B select and operation
//   dmem_req_o, dmem_we_o data access request and write enable
//   mem_to_reg_o, rf_we_o writeback source and register file write enable
//   illegal_o             sticky illegal-instruction flag
//   state_o               current state (debug)
//   cycle_cnt_o, retired_cnt_o  performance counters
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en_i,
   input  logic [INST_WIDTH-1:0] instr_i,
   input  logic                  imem_ready_i,
   input  logic                  dmem_ready_i,
   input  logic                  alu_zero_i,
   output logic                  imem_req_o,
   output logic                  ir_load_o,
   output logic                  pc_write_o,
   output logic                  pc_src_o,
   output logic                  alu_src_b_o,
   output alu_ctrl_t             alu_ctrl_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic                  mem_to_reg_o,
   output logic                  rf_we_o,
   output logic                  illegal_o,
   output logic [2:0]            state_o,
   output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
   output logic [CNT_WIDTH-1:0]  retired_cnt_o
);

   ctrl_state_t state_q, state_d;
   op_class_t   op_q;
   alu_ctrl_t   alu_q;
   logic        dec_illegal_q;
   logic        illegal_q, illegal_d;

   alu_ctrl_t   dec_alu;
   op_class_t   dec_op;
   logic        dec_illegal;

   // Operand/immediate fields belong to the datapath, not the controller.
   logic        unused_instr;
   assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

   // Decode straight off instr_i so the result is registered alongside the IR.
   multicycle_ctrl_fsm_alu_ctrl_decoder u_alu_ctrl_decoder (
      .opcode_i   (instr_i[6:0]),
      .funct3_i   (instr_i[14:12]),
      .funct7_i   (instr_i[31:25]),
      .alu_ctrl_o (dec_alu),
      .op_class_o (dec_op),
      .illegal_o  (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StFetch;
         op_q          <= OpArith;
         alu_q         <= AluAdd;
         dec_illegal_q <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         if (ir_load_o) begin
            op_q          <= dec_op;
            alu_q         <= dec_alu;
            dec_illegal_q <= dec_illegal;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      imem_req_o   = 1'b0;
      ir_load_o    = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      alu_src_b_o  = 1'b0;
      alu_ctrl_o   = AluAdd;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      rf_we_o      = 1'b0;
      case (state_q)
         StFetch: begin
            if (en_i) begin
               imem_req_o = 1'b1;
               if (imem_ready_i) begin
                  ir_load_o = 1'b1;
                  state_d   = StDecode;
               end
            end
         end
         StDecode: begin
            if (dec_illegal_q) begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end else begin
               alu_ctrl_o = alu_q;
               state_d    = StExecute;
            end
         end
         StExecute: begin
            alu_ctrl_o = alu_q;
            case (op_q)
               OpArith: state_d = StWriteback;
               OpLoad, OpStore: begin
                  alu_src_b_o = 1'b1;
                  state_d     = StMem;
               end
               OpBranch: begin
                  pc_write_o = 1'b1;
                  pc_src_o   = alu_zero_i;
                  state_d    = StFetch;
               end
               default: state_d = StFetch;
            endcase
         end
         StMem: begin
            alu_ctrl_o  = alu_q;
            alu_src_b_o = 1'b1;
            dmem_req_o  = 1'b1;
            dmem_we_o   = (op_q == OpStore);
            if (dmem_ready_i) begin
               if (op_q == OpStore) begin
                  pc_write_o = 1'b1;
                  state_d    = StFetch;
               end else begin
                  state_d = StWriteback;
               end
            end
         end
         StWriteback: begin
            alu_ctrl_o   = alu_q;
            alu_src_b_o  = (op_q != OpArith);
            rf_we_o      = 1'b1;
            mem_to_reg_o = (op_q == OpLoad);
            pc_write_o   = 1'b1;
            state_d      = StFetch;
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   assign illegal_o = illegal_q;
   assign state_o   = state_q;

`ifdef CTRL_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cycle_cnt_q, retired_cnt_q;

   // Idle FETCH (en_i low) and HALT are not active cycles; both counters wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q   <= '0;
         retired_cnt_q <= '0;
      end else begin
         if (state_q != StHalt && !(state_q == StFetch && !en_i)) begin
            cycle_cnt_q <= cycle_cnt_q + CntOne;
         end
         if (pc_write_o) begin
            retired_cnt_q <= retired_cnt_q + CntOne;
         end
      end
   end

   assign cycle_cnt_o   = cycle_cnt_q;
   assign retired_cnt_o = retired_cnt_q;
`else
   assign cycle_cnt_o   = '0;
   assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
   import multicycle_ctrl_fsm_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_i;
   logic [31:0] instr_i;
   logic        imem_ready_i;
   logic        dmem_ready_i;
   logic        alu_zero_i;
   logic        imem_req_o;
   logic        ir_load_o;
   logic        pc_write_o;
   logic        pc_src_o;
   logic        alu_src_b_o;
   alu_ctrl_t   alu_ctrl_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        mem_to_reg_o;
   logic        rf_we_o;
   logic        illegal_o;
   logic [2:0]  state_o;
   logic [31:0] cycle_cnt_o;
   logic [31:0] retired_cnt_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.CNT_WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .en_i          (en_i),
      .instr_i       (instr_i),
      .imem_ready_i  (imem_ready_i),
      .dmem_ready_i  (dmem_ready_i),
      .alu_zero_i    (alu_zero_i),
      .imem_req_o    (imem_req_o),
      .ir_load_o     (ir_load_o),
      .pc_write_o    (pc_write_o),
      .pc_src_o      (pc_src_o),
      .alu_src_b_o   (alu_src_b_o),
      .alu_ctrl_o    (alu_ctrl_o),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .mem_to_reg_o  (mem_to_reg_o),
      .rf_we_o       (rf_we_o),
      .illegal_o     (illegal_o),
      .state_o       (state_o),
      .cycle_cnt_o   (cycle_cnt_o),
      .retired_cnt_o (retired_cnt_o)
   );

   // Per-instruction result record; alu=7 means EXECUTE was never reached.
   typedef struct {
      int alu;
      int cycles;
      int rfwe;
      int m2r;
      int pcw;
      int pcsrc;
      int dreq;
      int dwe;
      int illegal;
      int conflict;
   } rec_t;

   typedef struct {
      logic [31:0] instr;
      int          iwait;
      int          dwait;
      logic        zero;
      rec_t        exp;
   } vec_t;

   rec_t sb_q[$];
   vec_t vecs[$];

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [31:0] instr, input int iwait, input int dwait,
                                input logic zero, input int alu, input int cycles,
                                input int rfwe, input int m2r, input int pcw, input int pcsrc,
                                input int dreq, input int dwe, input int illegal);
      vec_t v;
      v.instr        = instr;
      v.iwait        = iwait;
      v.dwait        = dwait;
      v.zero         = zero;
      v.exp.alu      = alu;
      v.exp.cycles   = cycles;
      v.exp.rfwe     = rfwe;
      v.exp.m2r      = m2r;
      v.exp.pcw      = pcw;
      v.exp.pcsrc    = pcsrc;
      v.exp.dreq     = dreq;
      v.exp.dwe      = dwe;
      v.exp.illegal  = illegal;
      v.exp.conflict = 0;
      return v;
   endfunction

   task automatic do_reset();
      reset        = 1'b1;
      en_i         = 1'b0;
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      alu_zero_i   = 1'b0;
      instr_i      = 32'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Drives one instruction from FETCH to retirement (or HALT), pushing the expected
   // record first and popping/comparing once the DUT has produced its result.
   task automatic run_instr(input string name, input vec_t v, input bit compare);
      rec_t obs;
      rec_t exp;
      int   ireq;
      int   cyc;
      bit   done;
      sb_q.push_back(v.exp);
      obs.alu = 7; obs.cycles = 0; obs.rfwe = 0; obs.m2r = 0; obs.pcw = 0;
      obs.pcsrc = 0; obs.dreq = 0; obs.dwe = 0; obs.illegal = 0; obs.conflict = 0;
      ireq = 0; cyc = 0; done = 1'b0;
      en_i         = 1'b1;
      instr_i      = v.instr;
      alu_zero_i   = v.zero;
      imem_ready_i = (v.iwait == 0);
      dmem_ready_i = (v.dwait == 0);
      while (!done && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (imem_req_o) ireq++;
         if (state_o == StExecute) obs.alu = int'(alu_ctrl_o);
         if (dmem_req_o) begin
            obs.dreq++;
            if (dmem_we_o) obs.dwe = 1;
         end
         if (rf_we_o) begin
            obs.rfwe++;
            obs.m2r = int'(mem_to_reg_o);
         end
         if (imem_req_o && (pc_write_o || rf_we_o)) obs.conflict = 1;
         if (pc_write_o) begin
            obs.pcw++;
            obs.pcsrc = int'(pc_src_o);
         end
         if (pc_write_o || state_o == StHalt) begin
            done       = 1'b1;
            obs.cycles = cyc;
         end
         @(posedge clk);
         #1;
         imem_ready_i = (ireq >= v.iwait);
         dmem_ready_i = (obs.dreq >= v.dwait);
      end
      obs.illegal = int'(illegal_o);
      en_i = 1'b0;
      exp  = sb_q.pop_front();
      if (compare) begin
         check_eq({name, ".done"}, int'(done), 1);
         check_eq({name, ".alu"}, obs.alu, exp.alu);
         check_eq({name, ".cycles"}, obs.cycles, exp.cycles);
         check_eq({name, ".rf_we"}, obs.rfwe, exp.rfwe);
         check_eq({name, ".mem_to_reg"}, obs.m2r, exp.m2r);
         check_eq({name, ".pc_write"}, obs.pcw, exp.pcw);
         check_eq({name, ".pc_src"}, obs.pcsrc, exp.pcsrc);
         check_eq({name, ".dmem_req"}, obs.dreq, exp.dreq);
         check_eq({name, ".dmem_we"}, obs.dwe, exp.dwe);
         check_eq({name, ".illegal"}, obs.illegal, exp.illegal);
         check_eq({name, ".conflict"}, obs.conflict, exp.conflict);
      end
   endtask

   initial begin
      vec_t v;
      int   n;

      //           instr          iw dw z  alu cyc rf m2r pcw src dreq dwe ill
      vecs.push_back(mkv(32'h002081B3, 0, 0, 0, 2, 4, 1, 0, 1, 0, 0, 0, 0)); // ADD
      vecs.push_back(mkv(32'h402081B3, 0, 0, 0, 6, 4, 1, 0, 1, 0, 0, 0, 0)); // SUB
      vecs.push_back(mkv(32'h0020E1B3, 0, 0, 0, 1, 4, 1, 0, 1, 0, 0, 0, 0)); // OR
      vecs.push_back(mkv(32'h0020F1B3, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0)); // AND
      vecs.push_back(mkv(32'h0000B183, 0, 3, 0, 2, 8, 1, 1, 1, 0, 4, 0, 0)); // LD, 3 waits
      vecs.push_back(mkv(32'h0000B183, 0, 0, 0, 2, 5, 1, 1, 1, 0, 1, 0, 0)); // LD
      vecs.push_back(mkv(32'h0020B023, 0, 0, 0, 2, 4, 0, 0, 1, 0, 1, 1, 0)); // SD
      vecs.push_back(mkv(32'h0020B023, 0, 1, 0, 2, 5, 0, 0, 1, 0, 2, 1, 0)); // SD, 1 wait
      vecs.push_back(mkv(32'h00208063, 0, 0, 1, 6, 3, 0, 0, 1, 1, 0, 0, 0)); // BEQ taken
      vecs.push_back(mkv(32'h00208063, 0, 0, 0, 6, 3, 0, 0, 1, 0, 0, 0, 0)); // BEQ not taken
      vecs.push_back(mkv(32'h002081B3, 2, 0, 0, 2, 6, 1, 0, 1, 0, 0, 0, 0)); // ADD, 2 imem waits

      do_reset();
      @(negedge clk);
      check_eq("rst.state", int'(state_o), 0);
      check_eq("rst.imem_req", int'(imem_req_o), 0);
      check_eq("rst.pc_write", int'(pc_write_o), 0);
      check_eq("rst.rf_we", int'(rf_we_o), 0);
      check_eq("rst.alu_ctrl", int'(alu_ctrl_o), 2);
      check_eq("rst.illegal", int'(illegal_o), 0);
      check_eq("rst.cycle_cnt", int'(cycle_cnt_o), 0);
      check_eq("rst.retired_cnt", int'(retired_cnt_o), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_instr($sformatf("v%0d", i), vecs[i], 1'b1);
      end

      // Illegal encodings: ADDI opcode, OR with funct7 set, BNE.
      v = mkv(32'h00000013, 0, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 1);
      run_instr("ill_addi", v, 1'b1);
      en_i = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("halt.state", int'(state_o), 5);
      check_eq("halt.illegal_sticky", int'(illegal_o), 1);
      check_eq("halt.imem_req", int'(imem_req_o), 0);
      check_eq("halt.pc_write", int'(pc_write_o), 0);
      do_reset();
      @(negedge clk);
      check_eq("halt_rst.state", int'(state_o), 0);
      check_eq("halt_rst.illegal", int'(illegal_o), 0);
      @(posedge clk);
      #1;

      v = mkv(32'h4020E1B3, 0, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 1);
      run_instr("ill_or_f7", v, 1'b1);
      do_reset();
      v = mkv(32'h00209063, 0, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 1);
      run_instr("ill_bne", v, 1'b1);
      do_reset();

      // Reset while a load is stalled in MEM.
      en_i         = 1'b1;
      instr_i      = 32'h0000B183;
      imem_ready_i = 1'b1;
      dmem_ready_i = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (state_o != StMem && n < 20);
      check_eq("memrst.reached_mem", int'(state_o), 3);
      check_eq("memrst.dmem_req_before", int'(dmem_req_o), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      en_i  = 1'b0;
      @(negedge clk);
      check_eq("memrst.state", int'(state_o), 0);
      check_eq("memrst.dmem_req", int'(dmem_req_o), 0);
      check_eq("memrst.rf_we", int'(rf_we_o), 0);
      check_eq("memrst.pc_write", int'(pc_write_o), 0);
      @(posedge clk);
      #1;

      // Ten back-to-back ADDs for the performance counters.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         run_instr("add10", vecs[0], 1'b0);
      end
      @(negedge clk);
`ifdef CTRL_PERF_CNT_EN
      check_eq("perf.retired", int'(retired_cnt_o), 10);
      check_eq("perf.cycles", int'(cycle_cnt_o), 40);
`else
      check_eq("perf.retired", int'(retired_cnt_o), 0);
      check_eq("perf.cycles", int'(cycle_cnt_o), 0);
`endif
      check_eq("perf.idle_state", int'(state_o), 0);
      check_eq("perf.idle_imem_req", int'(imem_req_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
